// File: rtl/nanorv32_urom_seq_pkg.sv
// Shared definitions for the micro-ROM sequencer.
//   - FSM state encoding
//   - symbolic sequence indices (which ROM routine each seq_sel value selects)
//   - ROM word layout: {last, data}, so the last-mark sits at bit DATA_W
package nanorv32_urom_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } seq_state_t;

  localparam int SEQ_RESET     = 0;
  localparam int SEQ_IRQ_ENTRY = 1;
  localparam int SEQ_IRQ_EXIT  = 2;
  localparam int SEQ_SPARE     = 3;

  // A ROM word is one bit wider than the micro-instruction; the extra
  // top bit marks the final word of a routine.
  function automatic int rom_word_w(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int rom_last_pos(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/nanorv32_urom_table.sv
// Micro-ROM contents, purely combinational.
//   addr : ROM address
//   word : {last, data}; unlisted addresses read as all zeros
// Routines: reset @0, irq entry @16, irq exit @32, spare @48.
// Addresses 60..63 hold a routine with no end mark; reaching the top of
// the ROM through it is what the sequencer reports as an overrun.
module nanorv32_urom_table
  import nanorv32_urom_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0]             addr,
  output logic [rom_word_w(DATA_W)-1:0] word
);

  localparam int WORD_W = rom_word_w(DATA_W);

  function automatic logic [WORD_W-1:0] ent(input logic last, input logic [31:0] d);
    return {last, DATA_W'(d)};
  endfunction

  always_comb begin
    word = '0;
    case (addr)
      // reset routine
      ADDR_W'(0):  word = ent(1'b0, 32'h0000_0013);
      ADDR_W'(1):  word = ent(1'b0, 32'h0010_0093);
      ADDR_W'(2):  word = ent(1'b1, 32'h0020_0113);
      // interrupt entry
      ADDR_W'(16): word = ent(1'b0, 32'h3401_1173);
      ADDR_W'(17): word = ent(1'b0, 32'h3410_2573);
      ADDR_W'(18): word = ent(1'b1, 32'h3020_0073);
      // interrupt exit
      ADDR_W'(32): word = ent(1'b0, 32'h3410_9073);
      ADDR_W'(33): word = ent(1'b0, 32'h0000_0513);
      ADDR_W'(34): word = ent(1'b0, 32'h00a1_2023);
      ADDR_W'(35): word = ent(1'b1, 32'h3050_0073);
      // spare
      ADDR_W'(48): word = ent(1'b0, 32'h0000_0013);
      ADDR_W'(49): word = ent(1'b1, 32'h0000_100f);
      // unterminated tail routine
      ADDR_W'(60): word = ent(1'b0, 32'h0600_0613);
      ADDR_W'(61): word = ent(1'b0, 32'h0610_0693);
      ADDR_W'(62): word = ent(1'b0, 32'h0620_0713);
      ADDR_W'(63): word = ent(1'b0, 32'h0630_0793);
      default:     word = '0;
    endcase
  end

endmodule

// File: rtl/nanorv32_urom_seq.sv
// Micro-ROM sequencer: replays fixed micro-instruction routines into the
// decode stage over a registered valid/ready stream.
//   clk, rst_n          : clock, async active-low reset
//   seq_req, seq_sel    : start request (level, sampled in IDLE) and routine index
//   seq_ack             : one-cycle pulse when a request is taken
//   abort               : kill the running routine (highest priority)
//   instr, instr_valid,
//   instr_ready,
//   instr_last          : output stream; instr_last flags the final word
//   busy                : routine in progress
//   done                : one-cycle pulse after the final word is consumed
//   overrun_err         : sticky, set when the top of ROM is hit unterminated
module nanorv32_urom_seq
  import nanorv32_urom_seq_pkg::*;
#(
  parameter int                        DATA_W         = 32,
  parameter int                        ADDR_W         = 6,
  parameter int                        NUM_SEQ        = 4,
  parameter logic [NUM_SEQ*ADDR_W-1:0] ENTRY_ADDR     = {6'd48, 6'd32, 6'd16, 6'd0},
  parameter bit                        AUTO_RESET_SEQ = 1'b1,
  localparam int                       SEL_W          = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seq_req,
  input  logic [SEL_W-1:0]  seq_sel,
  output logic              seq_ack,
  input  logic              abort,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              instr_last,
  output logic              busy,
  output logic              done,
  output logic              overrun_err
);

  localparam int              WORD_W   = rom_word_w(DATA_W);
  localparam int              LAST_POS = rom_last_pos(DATA_W);
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  seq_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [DATA_W-1:0] instr_reg, instr_next;
  logic              valid_reg, valid_next;
  logic              last_reg, last_next;
  logic              ack_reg, ack_next;
  logic              done_reg, done_next;
  logic              overrun_reg, overrun_next;
  logic              pending_reg, pending_next;

  logic [WORD_W-1:0] rom_word;
  logic [SEL_W-1:0]  sel_eff;
  logic [ADDR_W-1:0] entry_addr;
  logic              accept, load, retire;
  logic              rom_last, at_top, word_last;

  nanorv32_urom_table #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_table (
    .addr (ptr_reg),
    .word (rom_word)
  );

  // The auto-start flag behaves like a request for the reset routine and
  // takes precedence over whatever seq_sel happens to carry.
  always_comb begin
    sel_eff = seq_sel;
    if (pending_reg || (32'(seq_sel) >= NUM_SEQ)) begin
      sel_eff = SEL_W'(SEQ_RESET);
    end
  end

  assign entry_addr = ENTRY_ADDR[int'(sel_eff)*ADDR_W +: ADDR_W];

  assign accept   = (state_reg == IDLE) && !abort && (seq_req || pending_reg);
  assign load     = (state_reg == RUN)  && !abort && (!valid_reg || instr_ready);
  assign retire   = (state_reg == LAST) && !abort && valid_reg && instr_ready;
  assign rom_last = rom_word[LAST_POS];
  assign at_top   = (ptr_reg == PTR_MAX);
  // The top ROM word always terminates a routine, marked or not.
  assign word_last = rom_last || at_top;

  // State register and output/datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      instr_reg   <= '0;
      valid_reg   <= 1'b0;
      last_reg    <= 1'b0;
      ack_reg     <= 1'b0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
      pending_reg <= AUTO_RESET_SEQ;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      instr_reg   <= instr_next;
      valid_reg   <= valid_next;
      last_reg    <= last_next;
      ack_reg     <= ack_next;
      done_reg    <= done_next;
      overrun_reg <= overrun_next;
      pending_reg <= pending_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept) state_next = RUN;
        RUN:     if (load && word_last) state_next = LAST;
        LAST:    if (retire) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output and datapath next values. When the consumer stalls a valid
  // word, load stays low so instr/last/ptr simply hold.
  always_comb begin
    ptr_next     = ptr_reg;
    instr_next   = instr_reg;
    valid_next   = valid_reg;
    last_next    = last_reg;
    overrun_next = overrun_reg;
    ack_next     = accept;
    done_next    = retire;
    pending_next = pending_reg && !accept && !abort;

    if (accept) begin
      ptr_next = entry_addr;
    end

    if (load) begin
      instr_next = rom_word[DATA_W-1:0];
      last_next  = word_last;
      valid_next = 1'b1;
      // Saturate at the top rather than wrapping back into the reset routine.
      ptr_next   = at_top ? ptr_reg : ptr_reg + ADDR_W'(1);
      if (at_top && !rom_last) begin
        overrun_next = 1'b1;
      end
    end

    if (retire || abort) begin
      valid_next = 1'b0;
      last_next  = 1'b0;
    end
  end

  assign seq_ack     = ack_reg;
  assign instr       = instr_reg;
  assign instr_valid = valid_reg;
  assign instr_last  = last_reg;
  assign busy        = (state_reg == RUN) || (state_reg == LAST);
  assign done        = done_reg;
  assign overrun_err = overrun_reg;

endmodule

// File: tb/tb_nanorv32_urom_seq.sv
// Self-checking bench for nanorv32_urom_seq. Expected streams come from a
// ROM image held here and a walk-until-end-mark rule; handshakes are
// checked word by word against that queue.
module tb_nanorv32_urom_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seq_req = 1'b0;
  logic [1:0]  seq_sel = 2'd0;
  logic        seq_ack;
  logic        abort = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        instr_last;
  logic        busy;
  logic        done;
  logic        overrun_err;

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [31:0] ref_data [64];
  bit          ref_last [64];
  int          ref_entry [4] = '{0, 16, 32, 60};
  logic [32:0] exp_q [$];
  bit          exp_overrun = 1'b0;

  nanorv32_urom_seq #(
    .DATA_W         (32),
    .ADDR_W         (6),
    .NUM_SEQ        (4),
    .ENTRY_ADDR     ({6'd60, 6'd32, 6'd16, 6'd0}),
    .AUTO_RESET_SEQ (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seq_req     (seq_req),
    .seq_sel     (seq_sel),
    .seq_ack     (seq_ack),
    .abort       (abort),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_last  (instr_last),
    .busy        (busy),
    .done        (done),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put_rom(input int a, input logic [31:0] d, input bit l);
    ref_data[a] = d;
    ref_last[a] = l;
  endtask

  // Expected words of a routine: from its entry up to the first end mark,
  // or up to the top address, which then counts as an overrun.
  task automatic build_expected(input int sel);
    int a;
    bit lst;
    exp_q.delete();
    a = ref_entry[sel];
    for (int k = 0; k < 64; k++) begin
      lst = ref_last[a] || (a == 63);
      exp_q.push_back({lst, ref_data[a]});
      if (a == 63 && !ref_last[a]) exp_overrun = 1'b1;
      if (lst) break;
      a++;
    end
  endtask

  task automatic start(input int sel);
    seq_sel = 2'(sel);
    seq_req = 1'b1;
    tick();
    seq_req = 1'b0;
    chk($sformatf("seq_ack sel%0d", sel), seq_ack, 1);
    chk($sformatf("first_word_latency sel%0d", sel), instr_valid, 0);
    build_expected(sel);
  endtask

  // mode 0: ready always high, 1: pattern 1,0,0,1,1, 2: random ready.
  task automatic stream(input string nm, input int mode, input bit inject);
    bit          pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int          cyc = 0;
    bit          held = 1'b0;
    logic [32:0] held_w = '0;
    logic [32:0] exp_w;
    int          stable_bad = 0;
    int          ack_bad = 0;
    int          done_bad = 0;
    bit          finished = 1'b0;
    bit          r;
    while (!finished && cyc < 300) begin
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = pat[cyc % 5];
      else                r = 1'($urandom_range(0, 1));
      if (inject) begin
        seq_req = (cyc == 1);
        seq_sel = 2'd3;
      end
      instr_ready = r;
      if (cyc > 0 && seq_ack) ack_bad++;
      if (done) done_bad++;
      if (instr_valid) begin
        if (held && {instr_last, instr} !== held_w) stable_bad++;
        if (r) begin
          exp_w = exp_q.pop_front();
          chk({nm, " word"}, {instr_last, instr}, exp_w);
          if (exp_q.size() == 0) finished = 1'b1;
        end
        held   = !r;
        held_w = {instr_last, instr};
      end else begin
        held = 1'b0;
      end
      tick();
      cyc++;
    end
    seq_req = 1'b0;
    chk({nm, " completed"}, finished, 1);
    chk({nm, " done_pulse"}, done, 1);
    chk({nm, " valid_after_last"}, instr_valid, 0);
    chk({nm, " busy_after_last"}, busy, 0);
    tick();
    chk({nm, " done_one_cycle"}, done, 0);
    chk({nm, " held_stable"}, stable_bad, 0);
    chk({nm, " no_ack_while_busy"}, ack_bad, 0);
    chk({nm, " no_early_done"}, done_bad, 0);
    chk({nm, " overrun_err"}, overrun_err, exp_overrun);
  endtask

  initial begin
    int nv;

    for (int a = 0; a < 64; a++) put_rom(a, 32'h0, 1'b0);
    put_rom(0,  32'h0000_0013, 1'b0);
    put_rom(1,  32'h0010_0093, 1'b0);
    put_rom(2,  32'h0020_0113, 1'b1);
    put_rom(16, 32'h3401_1173, 1'b0);
    put_rom(17, 32'h3410_2573, 1'b0);
    put_rom(18, 32'h3020_0073, 1'b1);
    put_rom(32, 32'h3410_9073, 1'b0);
    put_rom(33, 32'h0000_0513, 1'b0);
    put_rom(34, 32'h00a1_2023, 1'b0);
    put_rom(35, 32'h3050_0073, 1'b1);
    put_rom(48, 32'h0000_0013, 1'b0);
    put_rom(49, 32'h0000_100f, 1'b1);
    put_rom(60, 32'h0600_0613, 1'b0);
    put_rom(61, 32'h0610_0693, 1'b0);
    put_rom(62, 32'h0620_0713, 1'b0);
    put_rom(63, 32'h0630_0793, 1'b0);

    // Reset state.
    repeat (3) tick();
    chk("rst seq_ack", seq_ack, 0);
    chk("rst instr_valid", instr_valid, 0);
    chk("rst instr", instr, 0);
    chk("rst instr_last", instr_last, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst overrun_err", overrun_err, 0);

    // Automatic reset routine, cycle-exact with ready held high.
    instr_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("auto c1 seq_ack", seq_ack, 1);
    chk("auto c1 instr_valid", instr_valid, 0);
    tick();
    chk("auto c2 word", {instr_valid, instr_last, instr}, {2'b10, 32'h0000_0013});
    tick();
    chk("auto c3 word", {instr_valid, instr_last, instr}, {2'b10, 32'h0010_0093});
    tick();
    chk("auto c4 word", {instr_valid, instr_last, instr}, {2'b11, 32'h0020_0113});
    tick();
    chk("auto c5 done", done, 1);
    chk("auto c5 instr_valid", instr_valid, 0);
    chk("auto c5 busy", busy, 0);
    tick();
    chk("auto c6 done", done, 0);
    chk("auto c6 seq_ack", seq_ack, 0);
    chk("auto c6 busy", busy, 0);
    chk("auto overrun_err", overrun_err, 0);

    // Interrupt entry under backpressure.
    start(1);
    stream("sel1_backpressure", 1, 1'b0);

    // Abort on the second valid word, then restart the same routine.
    start(2);
    instr_ready = 1'b1;
    nv = 0;
    for (int k = 0; k < 20 && nv < 2; k++) begin
      if (instr_valid) nv++;
      if (nv < 2) tick();
    end
    chk("abort reach_second_word", nv, 2);
    chk("abort second_word", instr, ref_data[33]);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort instr_valid", instr_valid, 0);
    chk("abort instr_last", instr_last, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    tick();
    chk("abort no_done_later", done, 0);
    chk("abort no_ack", seq_ack, 0);
    start(2);
    stream("sel2_restart", 2, 1'b0);

    // Request for sel 3 while sel 1 runs must be ignored.
    start(1);
    stream("sel1_ignore_req", 0, 1'b1);

    // A handful of random routines with random backpressure.
    for (int n = 0; n < 4; n++) begin
      start(int'($urandom_range(0, 2)));
      stream($sformatf("random%0d", n), 2, 1'b0);
    end

    // Unterminated routine running into the top of ROM, then stickiness.
    start(3);
    stream("sel3_overrun", 2, 1'b0);
    start(0);
    stream("after_overrun", 2, 1'b0);

    // Asynchronous reset with a word stalled on the output.
    start(1);
    instr_ready = 1'b0;
    tick();
    tick();
    chk("mid_run instr_valid", instr_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst instr_valid", instr_valid, 0);
    chk("async_rst instr_last", instr_last, 0);
    chk("async_rst instr", instr, 0);
    chk("async_rst busy", busy, 0);
    chk("async_rst overrun_err", overrun_err, 0);
    chk("async_rst done", done, 0);
    chk("async_rst seq_ack", seq_ack, 0);
    exp_overrun = 1'b0;
    instr_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("auto_again seq_ack", seq_ack, 1);
    build_expected(0);
    stream("auto_again", 2, 1'b0);

    // Abort coinciding with the automatic start kills the pending request.
    #1 rst_n = 1'b0;
    tick();
    abort = 1'b1;
    rst_n = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_pending seq_ack", seq_ack, 0);
    chk("abort_pending busy", busy, 0);
    repeat (3) tick();
    chk("abort_pending stays_idle", {busy, seq_ack, instr_valid}, 3'b000);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
